uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_tx_fifo_drain.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmit engine: drains a first-word-fall-through FIFO and serialises each word
// as start bit, data bits LSB first, optional even parity, then one or two stop bits.
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             empty,
  input  logic [WIDTH-1:0] read_data,
  output logic             ren,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int CPB    = CLK_FREQ / BAUD;
  localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [BAUD_W-1:0]  baud_cnt, baud_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [WIDTH-1:0]   shift, shift_n;
  logic               parity_bit, par_n;
  logic               tx_n, ren_n, busy_n, done_n;
  logic               bit_end;

  // Every output is computed here one cycle ahead and lands in a flop, so tx never
  // sees a combinational path from the inputs.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = parity_bit;
    tx_n    = tx;
    ren_n   = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    bit_end = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        bit_n  = '0;
        if (tx_en && !empty) begin
          shift_n = read_data;
          par_n   = ^read_data;
          ren_n   = 1'b1;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = parity_bit;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shift_n = shift >> 1;
            tx_n    = shift_n[0];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // A reset mid-frame abandons the byte already popped from the FIFO.
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      ren        <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      parity_bit <= par_n;
      tx         <= tx_n;
      ren        <= ren_n;
      busy       <= busy_n;
      tx_done    <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: an 8N1 instance and an even-parity/2-stop instance,
// each fed by a queue-based FIFO and checked every cycle against a frame-level model.
module tb_uart_tx_fifo_drain;

  localparam int CPB  = 16;
  localparam int MAXC = 16384;

  logic clk_50Mhz = 1'b0;
  always #5 clk_50Mhz = ~clk_50Mhz;

  logic       rst;
  logic       tx_en   [2];
  logic       empty   [2];
  logic [7:0] rdata   [2];
  logic       ren     [2];
  logic       tx      [2];
  logic       busy    [2];
  logic       tx_done [2];

  uart_tx_fifo_drain #(.CLK_FREQ(16), .BAUD(1), .WIDTH(8), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .tx_en(tx_en[0]), .empty(empty[0]),
    .read_data(rdata[0]), .ren(ren[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  uart_tx_fifo_drain #(.CLK_FREQ(16), .BAUD(1), .WIDTH(8), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .tx_en(tx_en[1]), .empty(empty[1]),
    .read_data(rdata[1]), .ren(ren[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  logic [7:0] fq0 [$];
  logic [7:0] fq1 [$];

  int         tests;
  int         fails;
  int         cyc;
  int         pos   [2];
  logic [7:0] cur   [2];
  logic       mdone [2];

  logic tr_tx   [2][MAXC];
  logic tr_ren  [2][MAXC];
  logic tr_busy [2][MAXC];
  logic tr_done [2][MAXC];

  typedef struct {
    int          d;
    logic [7:0]  data;
    logic [11:0] bits;
  } vec_t;

  vec_t vt [4];

  function automatic int nbits(int d);
    return (d == 0) ? 10 : 12;
  endfunction

  // Line level of frame bit k: start, data LSB first, parity (instance 1), stop.
  function automatic logic frame_bit(int d, logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (d == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic int fsize(int d);
    return (d == 0) ? fq0.size() : fq1.size();
  endfunction

  task automatic refresh(int d);
    if (fsize(d) == 0) begin
      empty[d] = 1'b1;
      rdata[d] = 8'h00;
    end else begin
      empty[d] = 1'b0;
      rdata[d] = (d == 0) ? fq0[0] : fq1[0];
    end
  endtask

  task automatic push(int d, logic [7:0] b);
    if (d == 0) fq0.push_back(b);
    else        fq1.push_back(b);
    refresh(d);
  endtask

  task automatic pop(int d);
    if (d == 0 && fq0.size() != 0) void'(fq0.pop_front());
    if (d == 1 && fq1.size() != 0) void'(fq1.pop_front());
    refresh(d);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic model_edge(int d);
    mdone[d] = 1'b0;
    if (rst) begin
      pos[d] = -1;
    end else if (pos[d] < 0) begin
      if (tx_en[d] && !empty[d]) begin
        pos[d] = 0;
        cur[d] = rdata[d];
      end
    end else begin
      pos[d]++;
      if (pos[d] == nbits(d) * CPB) begin
        pos[d]   = -1;
        mdone[d] = 1'b1;
      end
    end
  endtask

  task automatic check(int d);
    logic [3:0] act, want;
    act = {tx[d], ren[d], busy[d], tx_done[d]};
    if (pos[d] < 0) want = {1'b1, 1'b0, 1'b0, mdone[d]};
    else            want = {frame_bit(d, cur[d], pos[d] / CPB), (pos[d] == 0), 1'b1, 1'b0};
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL model dut%0d cycle %0d: tx/ren/busy/done got %b expected %b",
               d, cyc, act, want);
    end
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk_50Mhz);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      check(d);
      if (cyc < MAXC) begin
        tr_tx[d][cyc]   = tx[d];
        tr_ren[d][cyc]  = ren[d];
        tr_busy[d][cyc] = busy[d];
        tr_done[d][cyc] = tx_done[d];
      end
      if (ren[d] === 1'b1) pop(d);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ren(int d, output int launch);
    launch = -1;
    for (int i = 0; i < 40 && launch < 0; i++) begin
      if (ren[d] === 1'b1) launch = cyc;
      else step();
    end
    if (launch < 0 && ren[d] === 1'b1) launch = cyc;
    if (launch < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_ren dut%0d: got no ren within 40 cycles, expected one", d);
    end
  endtask

  function automatic logic [11:0] decode(int d, int l);
    logic [11:0] v;
    int idx;
    v = '0;
    for (int k = 0; k < nbits(d); k++) begin
      idx = l + k * CPB + CPB / 2;
      if (idx >= 0 && idx < MAXC) v[k] = tr_tx[d][idx];
    end
    return v;
  endfunction

  function automatic int hold_errs(int d, int l, logic [11:0] bits);
    int e, idx;
    e = 0;
    for (int k = 0; k < nbits(d); k++)
      for (int j = 0; j < CPB; j++) begin
        idx = l + k * CPB + j;
        if (idx >= 0 && idx < MAXC && tr_tx[d][idx] !== bits[k]) e++;
      end
    return e;
  endfunction

  function automatic int count_ren(int d, int a, int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < MAXC && tr_ren[d][i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_busy(int d, int a, int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < MAXC && tr_busy[d][i] === 1'b1) n++;
    return n;
  endfunction

  // Follows one frame launched at sample l through to its tx_done pulse.
  task automatic check_frame(string name, int d, logic [11:0] bits, int l);
    int dc;
    int len;
    len = nbits(d) * CPB;
    dc  = -1;
    if (l < 0) return;
    for (int i = 0; i < len + 10 && dc < 0; i++) begin
      step();
      if (tx_done[d] === 1'b1) dc = cyc;
    end
    chk({name, "_done_latency"}, dc - l, len);
    chk({name, "_bits"}, decode(d, l), bits);
    chk({name, "_hold_errs"}, hold_errs(d, l, bits), 0);
    chk({name, "_busy_cycles"}, count_busy(d, l, l + len), len);
    chk({name, "_ren_count"}, count_ren(d, l, l + len), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, l2;
    int rl [$];

    vt[0] = '{0, 8'hA5, 12'h34A};
    vt[1] = '{1, 8'h07, 12'hE0E};
    vt[2] = '{0, 8'hC3, 12'h386};
    vt[3] = '{1, 8'h5A, 12'hCB4};

    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tx_en[d] = 1'b0;
      pos[d]   = -1;
      mdone[d] = 1'b0;
      cur[d]   = 8'h00;
      refresh(d);
    end

    // Reset held with a ready FIFO: line idle throughout, pop right after release.
    tx_en[0] = 1'b1;
    push(0, 8'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", {tx[0], ren[0], busy[0], tx_done[0]}, 4'b1000);
    end
    rst = 1'b0;
    step();
    chk("first_ren_after_reset", ren[0], 1);
    check_frame("reset_0x11", 0, 12'h222, cyc);
    tx_en[0] = 1'b0;
    run(4);

    // Single frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      tx_en[vt[i].d] = 1'b1;
      push(vt[i].d, vt[i].data);
      wait_ren(vt[i].d, l);
      check_frame($sformatf("vec%0d", i), vt[i].d, vt[i].bits, l);
      tx_en[vt[i].d] = 1'b0;
      run(3);
    end

    // Back-to-back frames from a pre-filled FIFO.
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    run(2);
    tx_en[0] = 1'b1;
    wait_ren(0, l);
    run(3 * 161 + 40);
    if (l >= 0) for (int i = l; i <= cyc; i++) if (tr_ren[0][i] === 1'b1) rl.push_back(i);
    chk("b2b_ren_count", rl.size(), 3);
    if (rl.size() >= 3) begin
      chk("b2b_gap1", rl[1] - rl[0], 161);
      chk("b2b_gap2", rl[2] - rl[1], 161);
      chk("b2b_0x00", decode(0, rl[0]), 12'h200);
      chk("b2b_0xFF", decode(0, rl[1]), 12'h3FE);
      chk("b2b_0x3C", decode(0, rl[2]), 12'h278);
      for (int i = 1; i < 3; i++) begin
        chk("b2b_idle_gap", {tr_busy[0][rl[i]-2], tr_busy[0][rl[i]-1], tr_tx[0][rl[i]-1]}, 3'b101);
      end
    end
    chk("b2b_empty_after", empty[0], 1);
    tx_en[0] = 1'b0;
    run(3);

    // tx_en dropped mid-frame: frame finishes, next byte waits for re-enable.
    push(0, 8'h55);
    push(0, 8'h12);
    tx_en[0] = 1'b1;
    wait_ren(0, l);
    run(40);
    tx_en[0] = 1'b0;
    run(160);
    if (l >= 0) begin
      chk("gate_ren_count", count_ren(0, l, cyc), 1);
      chk("gate_0x55", decode(0, l), 12'h2AA);
      chk("gate_done", tr_done[0][l+160], 1);
    end
    tx_en[0] = 1'b1;
    step();
    chk("gate_restart_ren", ren[0], 1);
    check_frame("gate_0x12", 0, 12'h224, cyc);
    run(3);

    // Reset during data bit 3: line snaps idle, no tx_done, fresh pop afterwards.
    push(0, 8'hC3);
    wait_ren(0, l);
    run(69);
    push(0, 8'h5A);
    rst = 1'b1;
    step();
    l2 = cyc;
    chk("midrst_line", {tx[0], busy[0], tx_done[0]}, 3'b100);
    step();
    chk("midrst_no_done", tx_done[0], 0);
    rst = 1'b0;
    step();
    chk("midrst_fresh_ren", ren[0], 1);
    if (l >= 0) chk("midrst_partial_bits", decode(0, l) & 12'h01F, 12'h006);
    chk("midrst_ren_total", count_ren(0, l2, cyc), 1);
    check_frame("midrst_0x5A", 0, 12'h2B4, cyc);

    // Randomised traffic on both instances against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 39) == 0 && fsize(d) < 6) push(d, 8'($urandom));
        if ($urandom_range(0, 149) == 0) tx_en[d] = ~tx_en[d];
      end
      rst = ($urandom_range(0, 1999) == 0);
      step();
    end
    rst = 1'b0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
